// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit -- instruction-fetch stage with IF/ID pipeline register.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              PCWrite,
  input  logic              Write_IF_ID,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_ID,
  output logic [WORD_W-1:0] instr_ID,
  output logic [WORD_W-1:0] pc_ID,
  output logic [WORD_W-1:0] npc_ID,
  output logic              valid_ID
);

  localparam logic [WORD_W-1:0] C_PC_STEP = WORD_W'(4);

  typedef enum logic [1:0] {
    S_RUN              = 2'd0,
    S_REDIRECT_PENDING = 2'd1,
    S_HALTED           = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] tgt_q, tgt_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pcid_q, pcid_d;
  logic [WORD_W-1:0] npcid_q, npcid_d;
  logic              valid_q, valid_d;

  logic [WORD_W-1:0] w_pc_plus4;
  logic              w_redirect_live;

  assign w_pc_plus4 = pc_q + C_PC_STEP;
  // Once halted, redirects are wrong-path noise and must not even flush IF/ID.
  assign w_redirect_live = redirect_en && (state_q != S_HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_RUN;
      pc_q    <= PC_INIT;
      tgt_q   <= '0;
      instr_q <= '0;
      pcid_q  <= '0;
      npcid_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pcid_q  <= pcid_d;
      npcid_q <= npcid_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pcid_d  = pcid_q;
    npcid_d = npcid_q;
    valid_d = valid_q;

    // IF/ID register: hold, load or bubble; a live redirect beats the hold.
    if (Write_IF_ID && !w_redirect_live) begin
      valid_d = valid_q;
    end else if (ihit && !PCWrite && (state_q == S_RUN) && !redirect_en) begin
      instr_d = imemload;
      pcid_d  = pc_q;
      npcid_d = w_pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = '0;
      pcid_d  = '0;
      npcid_d = '0;
      valid_d = 1'b0;
    end

    case (state_q)
      S_RUN: begin
        if (redirect_en && ihit) begin
          pc_d = redirect_pc;
        end else if (redirect_en) begin
          // Read still outstanding: keep imemaddr stable, park the target.
          tgt_d   = redirect_pc;
          state_d = S_REDIRECT_PENDING;
        end else if (ihit && !PCWrite && !Write_IF_ID) begin
          pc_d = w_pc_plus4;
        end
        if (halt_ID && !redirect_en) begin
          state_d = S_HALTED;
        end
      end
      S_REDIRECT_PENDING: begin
        if (redirect_en) begin
          tgt_d = redirect_pc;
        end
        if (ihit) begin
          pc_d    = redirect_en ? redirect_pc : tgt_q;
          state_d = S_RUN;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign imemaddr = pc_q;
  assign imemREN  = (state_q != S_HALTED);
  assign instr_ID = instr_q;
  assign pc_ID    = pcid_q;
  assign npc_ID   = npcid_q;
  assign valid_ID = valid_q;

endmodule
`default_nettype wire
